// File: rtl/bcdbin_arbiter.sv
// Round-robin arbiter sharing one 2-digit BCD-to-binary converter between N requesters.
// Latches and validates the granted digits, runs the converter handshake, returns result or error.
module bcdbin_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [4*N-1:0] dig1_in,
   input  logic [4*N-1:0] dig0_in,
   output logic [N-1:0]   ack,
   output logic [N-1:0]   rsp_valid,
   output logic [6:0]     rsp_bin,
   output logic           rsp_err,
   output logic           busy,
   output logic           conv_start,
   output logic [3:0]     conv_dig1,
   output logic [3:0]     conv_dig0,
   input  logic           conv_ready,
   input  logic           conv_done_tick,
   input  logic [6:0]     conv_bin
);

   localparam int IDW = (N > 1) ? $clog2(N) : 1;
   localparam int CW  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gnt;
   logic [CW-1:0]  cnt;
   logic           err_pend;

   logic [2*N-1:0] rot;
   logic           found;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] sel_next;
   logic [3:0]     sel_d1;
   logic [3:0]     sel_d0;
   logic           sel_bad;
   int             pos;

   // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
   always_comb begin
      rot   = {req, req} >> ptr;
      found = 1'b0;
      sel   = '0;
      pos   = 0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            pos   = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            sel   = IDW'(pos);
         end
      end
      sel_next = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
      sel_d1   = '0;
      sel_d0   = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == IDW'(i)) begin
            sel_d1 = dig1_in[4*i +: 4];
            sel_d0 = dig0_in[4*i +: 4];
         end
      end
      sel_bad = (sel_d1 > 4'd9) || (sel_d0 > 4'd9);
   end

   assign conv_start = (state == ISSUE) && conv_ready;

   // An invalid-digit grant spends one extra RESP cycle so its response trails the ack by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         cnt       <= '0;
         err_pend  <= 1'b0;
         ack       <= '0;
         rsp_valid <= '0;
         rsp_bin   <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         conv_dig1 <= '0;
         conv_dig0 <= '0;
      end else begin
         ack       <= '0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt       <= sel;
                  ack[sel]  <= 1'b1;
                  ptr       <= sel_next;
                  conv_dig1 <= sel_d1;
                  conv_dig0 <= sel_d0;
                  busy      <= 1'b1;
                  if (sel_bad) begin
                     err_pend <= 1'b1;
                     state    <= RESP;
                  end else begin
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (conv_ready) begin
                  cnt   <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + CW'(1);
               if (conv_done_tick) begin
                  rsp_valid[gnt] <= 1'b1;
                  rsp_bin        <= conv_bin;
                  rsp_err        <= 1'b0;
                  state          <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_valid[gnt] <= 1'b1;
                  rsp_bin        <= '0;
                  rsp_err        <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               if (err_pend) begin
                  err_pend       <= 1'b0;
                  rsp_valid[gnt] <= 1'b1;
                  rsp_bin        <= '0;
                  rsp_err        <= 1'b1;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
